// File: rtl/i2s_tx.sv
// Master-mode I2S transmitter: pulls DW-bit samples from a FIFO read port and
// serializes them MSB first on BCLK/LRCLK/SDATA, left slot then right slot.
module i2s_tx #(
    parameter int DW      = 24,
    parameter int SLOT_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    output logic          o_rd,
    input  logic [DW-1:0] i_rdata,
    input  logic          i_rempty,
    output logic          o_bclk,
    output logic          o_lrclk,
    output logic          o_sdata,
    output logic          o_underflow,
    output logic          o_busy
);

    localparam int DCW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BCW = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [DCW-1:0]    div_ctr, div_nx;
    logic [BCW-1:0]    bit_ctr, bit_nx;
    logic [SLOT_W-1:0] shreg, shreg_nx;
    logic [DW-1:0]     hold, hold_nx;
    logic              bclk_nx, lrclk_nx, sdata_nx;
    logic              first, first_nx;
    logic              fall;

    assign o_busy = (state == RUN);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_nx    = state;
        div_nx      = div_ctr;
        bit_nx      = bit_ctr;
        shreg_nx    = shreg;
        hold_nx     = hold;
        bclk_nx     = o_bclk;
        lrclk_nx    = o_lrclk;
        sdata_nx    = o_sdata;
        first_nx    = first;
        fall        = 1'b0;
        o_rd        = 1'b0;
        o_underflow = 1'b0;

        case (state)
            IDLE: begin
                if (i_en) begin
                    state_nx = RUN;
                    div_nx   = '0;
                    bit_nx   = BCW'(SLOT_W - 2);
                    lrclk_nx = 1'b1;
                    first_nx = 1'b1;
                end
            end
            RUN: begin
                if (div_ctr == DCW'(CLK_DIV - 1)) begin
                    div_nx  = '0;
                    bclk_nx = ~o_bclk;
                    fall    = o_bclk;
                end else begin
                    div_nx = div_ctr + DCW'(1);
                end

                if (fall) begin
                    bit_nx = (bit_ctr == BCW'(SLOT_W - 1)) ? '0 : bit_ctr + BCW'(1);
                    if (bit_nx == BCW'(SLOT_W - 1)) begin
                        // Fetch point: flip channel, shift out the last bit of the old slot.
                        lrclk_nx = ~o_lrclk;
                        shreg_nx = shreg << 1;
                        sdata_nx = shreg[SLOT_W-2];
                        first_nx = 1'b0;
                        if (!lrclk_nx && !i_en && !first) begin
                            state_nx = IDLE;
                            div_nx   = '0;
                            bit_nx   = '0;
                            shreg_nx = '0;
                            hold_nx  = '0;
                            bclk_nx  = 1'b0;
                            lrclk_nx = 1'b1;
                            sdata_nx = 1'b0;
                        end else if (!i_rempty) begin
                            o_rd    = 1'b1;
                            hold_nx = i_rdata;
                        end else begin
                            hold_nx     = '0;
                            o_underflow = 1'b1;
                        end
                    end else if (bit_nx == '0) begin
                        // Slot start, one BCLK after the LRCLK edge.
                        shreg_nx = SLOT_W'(hold) << (SLOT_W - DW);
                        sdata_nx = hold[DW-1];
                    end else begin
                        shreg_nx = shreg << 1;
                        sdata_nx = shreg[SLOT_W-2];
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: hold and shreg are plain registers, so they are cleared here like the counters.
            state   <= IDLE;
            div_ctr <= '0;
            bit_ctr <= '0;
            shreg   <= '0;
            hold    <= '0;
            first   <= 1'b0;
            o_bclk  <= 1'b0;
            o_lrclk <= 1'b1;
            o_sdata <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values together.
            state   <= state_nx;
            div_ctr <= div_nx;
            bit_ctr <= bit_nx;
            shreg   <= shreg_nx;
            hold    <= hold_nx;
            first   <= first_nx;
            o_bclk  <= bclk_nx;
            o_lrclk <= lrclk_nx;
            o_sdata <= sdata_nx;
        end
    end

endmodule
